// File: rtl/netlist_misr_collector.sv
// Frame-based MISR signature collector for the INV/OAI222 gate-array result bus.
// Accepts frame_len words through a valid/ready input and presents one signature per frame.
module netlist_misr_collector #(
   parameter int unsigned         WIDTH = 41,
   parameter int unsigned         CNT_W = 8,
   parameter logic [WIDTH-1:0]    POLY  = 41'h9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic [WIDTH-1:0] sig_data,
   output logic             busy,
   output logic             err,
   input  logic             clr_err
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_next;
   logic [WIDTH-1:0] misr, misr_next;
   logic [CNT_W-1:0] count;
   logic             accept, start_ok, last_word, err_set;

   assign accept    = in_valid && in_ready;
   assign start_ok  = start && (state == IDLE) && (frame_len != '0);
   assign last_word = accept && (count == CNT_ONE);
   // A start is a protocol error unless it launches a frame from IDLE.
   assign err_set   = start && !start_ok;
   assign misr_next = {misr[WIDTH-2:0], 1'b0} ^ (misr[WIDTH-1] ? POLY : '0) ^ in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_ok) state_next = COLLECT;
         COLLECT: if (last_word) state_next = HOLD;
         HOLD:    if (sig_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == COLLECT);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misr      <= '0;
         count     <= '0;
         sig_data  <= '0;
         sig_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (start_ok) begin
            misr  <= '0;
            count <= frame_len;
         end else if (accept) begin
            misr  <= misr_next;
            count <= count - CNT_ONE;
         end
         if (last_word) begin
            sig_data <= misr_next;
         end
         sig_valid <= (state_next == HOLD);
         if (err_set) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/netlist_misr_collector.md
NETLIST_MISR_COLLECTOR -- requirements
Module: netlist_misr_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 41, giving the width of the captured gate-array result vector.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the frame-length counter.
REQ-003 SHALL have parameter POLY, default 41'h9 (x^41+x^3+1), giving the MISR feedback taps.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a frame-start request.
REQ-007 SHALL have port frame_len, input, CNT_W, the number of words per frame, sampled on an accepted start.
REQ-008 SHALL have port in_valid, input, 1, meaning upstream result word valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the collector accepts a word this cycle.
REQ-010 SHALL have port in_data, input, WIDTH, the result vector (output bus C of the upstream INV/OAI222 array).
REQ-011 SHALL have port sig_valid, output, 1, meaning the signature is available.
REQ-012 SHALL have port sig_ready, input, 1, meaning the consumer takes the signature.
REQ-013 SHALL have port sig_data, output, WIDTH, the frame signature.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port err, output, 1, a sticky protocol-error flag.
REQ-016 SHALL have port clr_err, input, 1, a synchronous clear for err.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT and HOLD.
REQ-018 In IDLE, start=1 with frame_len!=0 SHALL clear the MISR to 0, load the remaining-word count with frame_len, and enter COLLECT the next cycle.
REQ-019 In IDLE, start=1 with frame_len==0 SHALL be ignored: the state stays IDLE and err is set.
REQ-020 in_ready SHALL be 1 only in COLLECT; it SHALL be combinational from state only and SHALL NOT depend on in_valid.
REQ-021 A word SHALL be accepted on in_valid&&in_ready; on acceptance the MISR SHALL update as misr_next = ((misr<<1) truncated to WIDTH) ^ (misr[WIDTH-1] ? POLY : 0) ^ in_data, and the count SHALL decrement.
REQ-022 An acceptance that brings the count from 1 to 0 SHALL move the state to HOLD, with sig_valid=1 and sig_data=the final MISR on the next cycle (1-cycle latency from the last accept).
REQ-023 In HOLD, sig_data and sig_valid SHALL stay stable until sig_ready=1; sig_valid&&sig_ready SHALL return the state to IDLE the next cycle.
REQ-024 sig_valid SHALL be registered and be 1 only in HOLD; sig_data SHALL hold its last value outside HOLD.
REQ-025 start=1 in COLLECT or HOLD SHALL be ignored and SHALL set err; the frame in progress SHALL be unaffected.
REQ-026 in_valid in IDLE or HOLD SHALL be back-pressured (not accepted, not an error).
REQ-027 clr_err=1 SHALL clear err; if a set condition occurs in the same cycle, the set SHALL win.
REQ-028 In-flight count arithmetic SHALL be unsigned CNT_W bits and SHALL NOT wrap, because decrement occurs only while the count is at least 1.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, misr=0, count=0, sig_data=0, sig_valid=0, in_ready=0, busy=0 and err=0, including in mid-frame.
REQ-030 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-031 start, frame_len=1; in_data=41'h1 -> sig_valid 1 cycle after the accept, sig_data=41'h1.
REQ-032 frame_len=2; words 41'h100_0000_0000 then 41'h0 -> sig_data=41'h9 (MSB feedback through POLY).
REQ-033 frame_len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 accepts and sig_data=41'h5 for words 1,0,1; hold sig_ready=0 for 5 cycles -> sig_data stable and in_ready=0 throughout.
REQ-034 start with frame_len=0 -> state stays IDLE and err=1; clr_err pulse -> err=0; start pulse during COLLECT -> err=1 and the frame still completes with the correct signature.
REQ-035 rst asserted after 2 of 4 words -> all outputs at reset values immediately; a new frame_len=1 frame with 41'h3 -> sig_data=41'h3.
